// File: rtl/crp16_mem_pkg.sv
// rtl/crp16_mem_pkg.sv - MMIO map, output FIFO geometry and STATUS layout for the CRP16 memory responder
package crp16_mem_pkg;

    localparam logic [15:0] MMIO_BASE   = 16'hFF00;
    localparam logic [15:0] ADDR_OUT    = 16'hFF00;
    localparam logic [15:0] ADDR_STATUS = 16'hFF01;
    localparam logic [15:0] ADDR_CYC_LO = 16'hFF02;
    localparam logic [15:0] ADDR_CYC_HI = 16'hFF03;

    localparam int FIFO_DEPTH = 4;
    localparam int FIFO_PTR_W = 2;
    localparam int FIFO_CNT_W = 3;

    localparam int STATUS_OVF_BIT  = 4;
    localparam int STATUS_FULL_BIT = 3;

    // The whole top 256-word page belongs to MMIO; nothing there reaches RAM.
    function automatic logic is_mmio(input logic [15:0] addr);
        return addr[15:8] == MMIO_BASE[15:8];
    endfunction

endpackage

// File: rtl/crp16_mem_out_fifo.sv
// rtl/crp16_mem_out_fifo.sv - 4-entry output FIFO with sticky overflow flag
module crp16_mem_out_fifo
    import crp16_mem_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [15:0]           push_data,
    input  logic                  pop,
    input  logic                  clr_overflow,
    output logic [15:0]           head_data,
    output logic                  valid,
    output logic                  full,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  overflow
);

    logic [15:0]           slots [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] rd_ptr;
    logic [FIFO_PTR_W-1:0] wr_ptr;
    logic                  pop_ok;
    logic                  push_ok;
    logic                  drop;

    assign valid     = (count != '0);
    assign full      = (count == FIFO_CNT_W'(FIFO_DEPTH));
    assign head_data = valid ? slots[rd_ptr] : 16'h0000;

    // A pop on an empty FIFO is meaningless; a push into a full FIFO only
    // fits when the head leaves on the same edge.
    assign pop_ok  = pop & valid;
    assign push_ok = push & (~full | pop_ok);
    assign drop    = push & full & ~pop_ok;

    // Entry storage carries no reset; the head mux hides stale contents.
    always_ff @(posedge clock) begin
        if (reset && push_ok) begin
            slots[wr_ptr] <= push_data;
        end
    end

    // Pointer, occupancy and overflow bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_ok && !pop_ok) begin
                count <= count + 1'b1;
            end else if (!push_ok && pop_ok) begin
                count <= count - 1'b1;
            end
            overflow <= (overflow & ~clr_overflow) | drop;
        end
    end

endmodule

// File: rtl/crp16_mem_responder.sv
// rtl/crp16_mem_responder.sv - dual-port RAM plus MMIO output FIFO; CRP16_MEM_CYCLE_COUNTER_EN adds the cycle counter
module crp16_mem_responder
    import crp16_mem_pkg::*;
#(
    parameter int RAM_AW = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] address_a,
    output logic [15:0] q_a,
    input  logic [15:0] address_b,
    input  logic [15:0] data_b,
    input  logic        wren_b,
    output logic [15:0] q_b,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    logic [15:0]           ram [RAM_DEPTH];
    logic                  mmio_a;
    logic                  mmio_b;
    logic                  fifo_push;
    logic                  status_wr;
    logic                  fifo_full;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                  fifo_overflow;
    logic [15:0]           status_rd;
    logic [15:0]           cyc_lo_rd;
    logic [15:0]           cyc_hi_rd;
    logic [15:0]           mmio_rd;

    assign mmio_a    = is_mmio(address_a);
    assign mmio_b    = is_mmio(address_b);
    assign fifo_push = wren_b & (address_b == ADDR_OUT);
    assign status_wr = wren_b & (address_b == ADDR_STATUS);

    // RAM writes land on the edge, so a same-cycle read still sees the old word.
    always_ff @(posedge clock) begin
        if (reset && wren_b && !mmio_b) begin
            ram[address_b[RAM_AW-1:0]] <= data_b;
        end
    end

    assign q_a = mmio_a ? 16'h0000 : ram[address_a[RAM_AW-1:0]];

    crp16_mem_out_fifo u_out_fifo (
        .clock        (clock),
        .reset        (reset),
        .push         (fifo_push),
        .push_data    (data_b),
        .pop          (out_ready),
        .clr_overflow (status_wr),
        .head_data    (out_data),
        .valid        (out_valid),
        .full         (fifo_full),
        .count        (fifo_count),
        .overflow     (fifo_overflow)
    );

    always_comb begin
        status_rd                  = 16'h0000;
        status_rd[FIFO_CNT_W-1:0]  = fifo_count;
        status_rd[STATUS_FULL_BIT] = fifo_full;
        status_rd[STATUS_OVF_BIT]  = fifo_overflow;
    end

`ifdef CRP16_MEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_count;
    logic [31:0] snapshot;

    // Free-running counter; a CYC_LO write freezes its current value for readback.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cycle_count <= 32'h0;
            snapshot    <= 32'h0;
        end else begin
            cycle_count <= cycle_count + 32'h1;
            if (wren_b && (address_b == ADDR_CYC_LO)) begin
                snapshot <= cycle_count;
            end
        end
    end

    assign cyc_lo_rd = snapshot[15:0];
    assign cyc_hi_rd = snapshot[31:16];
`else
    assign cyc_lo_rd = 16'h0000;
    assign cyc_hi_rd = 16'h0000;
`endif

    // Port B MMIO read decode; OUT is write-only and unmapped slots read zero.
    always_comb begin
        mmio_rd = 16'h0000;
        case (address_b)
            ADDR_STATUS: mmio_rd = status_rd;
            ADDR_CYC_LO: mmio_rd = cyc_lo_rd;
            ADDR_CYC_HI: mmio_rd = cyc_hi_rd;
            default:     mmio_rd = 16'h0000;
        endcase
    end

    assign q_b = mmio_b ? mmio_rd : ram[address_b[RAM_AW-1:0]];

endmodule

// File: tb/tb_crp16_mem_responder.sv
// tb/tb_crp16_mem_responder.sv - directed self-checking bench for crp16_mem_responder
module tb_crp16_mem_responder;

    logic        clock;
    logic        reset;
    logic [15:0] address_a;
    logic [15:0] q_a;
    logic [15:0] address_b;
    logic [15:0] data_b;
    logic        wren_b;
    logic [15:0] q_b;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    crp16_mem_responder #(.RAM_AW(12)) dut (
        .clock     (clock),
        .reset     (reset),
        .address_a (address_a),
        .q_a       (q_a),
        .address_b (address_b),
        .data_b    (data_b),
        .wren_b    (wren_b),
        .q_b       (q_b),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write_b(input logic [15:0] addr, input logic [15:0] data);
        address_b = addr;
        data_b    = data;
        wren_b    = 1'b1;
        step();
        wren_b    = 1'b0;
    endtask

    task automatic check_status(input string tag, input logic [15:0] exp);
        address_b = 16'hFF01;
        #1;
        check(tag, q_b, exp);
    endtask

    logic [15:0] exp_cyc;
    logic [15:0] drain_exp [4];

    initial begin
        reset     = 1'b0;
        address_a = 16'h0000;
        address_b = 16'h0000;
        data_b    = 16'h0000;
        wren_b    = 1'b0;
        out_ready = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        address_a = 16'hFF01;
        address_b = 16'hFF01;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 16'h0000);
        check("rst_status", q_b, 16'h0000);
        check("qa_mmio_zero", q_a, 16'h0000);

        // Cycle counter: release reset just after an edge, present the CYC_LO
        // write after 100 further edges so the captured count is 100.
        reset = 1'b1;
        repeat (100) step();
`ifdef CRP16_MEM_CYCLE_COUNTER_EN
        exp_cyc = 16'd100;
`else
        exp_cyc = 16'h0000;
`endif
        write_b(16'hFF02, 16'h0000);
        address_b = 16'hFF02;
        #1;
        check("cyc_lo_snap", q_b, exp_cyc);
        repeat (3) step();
        check("cyc_lo_hold", q_b, exp_cyc);
        address_b = 16'hFF03;
        #1;
        check("cyc_hi", q_b, 16'h0000);

        // RAM read-during-write and aliasing.
        write_b(16'h0010, 16'h1234);
        address_b = 16'h0010;
        address_a = 16'h0010;
        data_b    = 16'hBEEF;
        wren_b    = 1'b1;
        #1;
        check("ram_old_b", q_b, 16'h1234);
        check("ram_old_a", q_a, 16'h1234);
        step();
        wren_b = 1'b0;
        #1;
        check("ram_new_b", q_b, 16'hBEEF);
        check("ram_new_a", q_a, 16'hBEEF);
        address_a = 16'h1010;
        #1;
        check("ram_alias", q_a, 16'hBEEF);

        write_b(16'h0F10, 16'h5555);
        write_b(16'hFF10, 16'h9999);
        address_a = 16'h0F10;
        #1;
        check("mmio_no_ram_write", q_a, 16'h5555);
        write_b(16'hFEFF, 16'h7777);
        address_a = 16'h0EFF;
        #1;
        check("ram_top_alias", q_a, 16'h7777);

        // FIFO fill with overflow, clear, then drain in order.
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) write_b(16'hFF00, 16'(i));
        check_status("status_full", 16'h000C);
        write_b(16'hFF00, 16'h0005);
        check_status("status_ovf", 16'h001C);
        address_b = 16'hFF00;
        address_a = 16'hFF00;
        #1;
        check("out_reads_zero_b", q_b, 16'h0000);
        check("out_reads_zero_a", q_a, 16'h0000);
        write_b(16'hFF01, 16'h0000);
        check_status("ovf_clear", 16'h000C);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", out_valid, 1'b1);
            check("drain_data", out_data, 16'(i));
            step();
        end
        check("drain_empty_valid", out_valid, 1'b0);
        check("drain_empty_data", out_data, 16'h0000);

        // out_ready while empty must not disturb a concurrent push.
        address_b = 16'hFF00;
        data_b    = 16'h5A5A;
        wren_b    = 1'b1;
        step();
        wren_b    = 1'b0;
        out_ready = 1'b0;
        check_status("empty_ready_push", 16'h0001);
        check("empty_ready_head", out_data, 16'h5A5A);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_status("empty_again", 16'h0000);

        // Push and pop together while full.
        write_b(16'hFF00, 16'h0011);
        write_b(16'hFF00, 16'h0022);
        write_b(16'hFF00, 16'h0033);
        write_b(16'hFF00, 16'h0044);
        out_ready = 1'b1;
        address_b = 16'hFF00;
        data_b    = 16'hAAAA;
        wren_b    = 1'b1;
        #1;
        check("full_pp_head", out_data, 16'h0011);
        step();
        wren_b    = 1'b0;
        out_ready = 1'b0;
        check_status("full_pp_status", 16'h000C);
        drain_exp[0] = 16'h0022;
        drain_exp[1] = 16'h0033;
        drain_exp[2] = 16'h0044;
        drain_exp[3] = 16'hAAAA;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("full_pp_order", out_data, drain_exp[i]);
            step();
        end
        out_ready = 1'b0;
        check("full_pp_empty", out_valid, 1'b0);

        // Asynchronous reset in the middle of a drain.
        write_b(16'hFF00, 16'h0001);
        write_b(16'hFF00, 16'h0002);
        write_b(16'hFF00, 16'h0003);
        check_status("pre_rst_count", 16'h0003);
        out_ready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", out_data, 16'h0000);
        check("mid_rst_status", q_b, 16'h0000);
        address_a = 16'h0010;
        #1;
        check("mid_rst_ram_kept", q_a, 16'hBEEF);
        address_b = 16'h0010;
        data_b    = 16'hDEAD;
        wren_b    = 1'b1;
        step();
        wren_b    = 1'b0;
        #1;
        check("rst_blocks_write", q_a, 16'hBEEF);
        reset     = 1'b1;
        out_ready = 1'b0;
        check_status("post_rst_status", 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/crp16_mem_responder.md
CRP16_MEM_RESPONDER -- requirements
Module: crp16_mem_responder

Interface
REQ-001 SHALL have parameter RAM_AW, default 12, RAM word-address width (4096 x 16-bit words).
REQ-002 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port address_a, input, 16, port A (fetch) read address.
REQ-005 SHALL have port q_a, output, 16, port A read data.
REQ-006 SHALL have ports address_b, input, 16, and data_b, input, 16: port B address and write data.
REQ-007 SHALL have port wren_b, input, 1, port B write enable.
REQ-008 SHALL have port q_b, output, 16, port B read data.
REQ-009 SHALL have ports out_data, output, 16; out_valid, output, 1; out_ready, input, 1: the output-FIFO drain handshake.

Function
REQ-010 SHALL decode addresses 0xFF00-0xFFFF as MMIO; all lower addresses map to RAM word addr[RAM_AW-1:0], aliasing modulo depth.
REQ-011 SHALL make q_a and q_b combinational: same-cycle data for the presented address, with no clocked read latency.
REQ-012 SHALL write data_b into RAM on the rising edge when wren_b=1 and address_b is a RAM address.
REQ-013 SHALL return the old value on q_a and q_b during a write cycle to the same address; the new value appears on the next cycle.
REQ-014 SHALL return 0x0000 on q_a for any MMIO address; port A never accesses MMIO side effects.
REQ-015 SHALL define the MMIO map as follows; unlisted MMIO reads return 0x0000 and unlisted writes are ignored:
- 0xFF00 OUT, write-only, reads 0.
- 0xFF01 STATUS.
- 0xFF02 CYC_LO.
- 0xFF03 CYC_HI.
REQ-016 SHALL push data_b into a 4-entry FIFO on a write to OUT; if the FIFO is full with no pop that cycle, the data is dropped and sticky overflow is set.
REQ-017 SHALL accept both operations on a simultaneous push and pop when the FIFO is full; count stays 4 and overflow is not set.
REQ-018 SHALL drive out_valid = (count != 0) and out_data = head entry, or 0x0000 when empty; pop occurs on an edge where out_valid & out_ready.
REQ-019 SHALL ignore out_ready when the FIFO is empty.
REQ-020 SHALL read STATUS as {11'b0, overflow, full, count[2:0]} in bits [15:0], with count in the range 0-4.
REQ-021 SHALL clear overflow on any write to STATUS; if a same-cycle drop occurs, overflow ends set.
REQ-022 SHALL preserve FIFO order, with pointers wrapping modulo 4.

Reset
REQ-023 SHALL, on reset low, immediately empty the FIFO (pointers=0, count=0), clear overflow, and zero the counter and snapshot; out_valid=0, out_data=0x0000.
REQ-024 SHALL NOT reset RAM contents.
REQ-025 SHALL abandon any write or pop in progress when reset is asserted mid-operation; no state change occurs while reset is low.

Configuration
REQ-026 SHALL, with CRP16_MEM_CYCLE_COUNTER_EN defined, run a 32-bit cycle counter that increments every clock and wraps 0xFFFFFFFF->0.
REQ-027 SHALL, with CRP16_MEM_CYCLE_COUNTER_EN defined, latch counter[31:0] into a 32-bit snapshot on any write to CYC_LO; CYC_LO/CYC_HI read snapshot[15:0]/snapshot[31:16].
REQ-028 SHALL, without CRP16_MEM_CYCLE_COUNTER_EN, generate no counter or snapshot logic; CYC_LO/CYC_HI read 0x0000 and writes to them are ignored.

Structure
REQ-029 SHALL place in shared package crp16_mem_pkg:
- the MMIO base and register addresses;
- FIFO depth 4;
- STATUS bit positions.
REQ-030 SHALL implement the FIFO as sub-module crp16_mem_out_fifo, with push/pop/full/count/overflow ports.

Verification
REQ-031 SHALL cover RAM read/write: wren_b=1 addr 0x0010 data 0xBEEF -> q_b=old value that cycle; next cycle q_b=0xBEEF and q_a(0x0010)=0xBEEF; addr 0x1010 reads 0xBEEF (alias).
REQ-032 SHALL cover FIFO fill: write 0x0001..0x0005 to 0xFF00 with out_ready=0 -> STATUS=0x000C after 4 writes, 0x001C after the 5th; then drain -> out_data 1,2,3,4, then out_valid=0.
REQ-033 SHALL cover full push+pop: FIFO full, out_ready=1, write 0xAAAA to OUT -> count stays 4, overflow=0, 0xAAAA is output last.
REQ-034 SHALL cover overflow clear: write 0 to 0xFF01 after an overflow -> STATUS bit4=0, count unchanged.
REQ-035 SHALL cover the cycle counter (macro defined): release reset, write 0xFF02 on cycle 100 -> CYC_LO equals the cycle count from reset release and is stable while held; undefined build -> reads 0x0000.
REQ-036 SHALL cover reset mid-drain: reset low with count=3 -> out_valid=0 immediately, STATUS=0x0000, RAM data retained.
